// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures retired instructions into a show-ahead FIFO drained over valid/ready.
// Optional RETIRE_TS_EN stores a free-running cycle timestamp with each entry.
module retire_trace_buffer #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned SEQ_W  = 16,
   parameter int unsigned DROP_W = 16
`ifdef RETIRE_TS_EN
   ,parameter int unsigned TS_W  = 32
`endif
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cap_en_i,
   input  logic [XLEN-1:0]            ret_pc_i,
   input  logic [XLEN-1:0]            ret_instr_i,
   input  logic [4:0]                 ret_rd_addr_i,
   input  logic [XLEN-1:0]            ret_rd_data_i,
   input  logic                       ret_stall_i,
   output logic                       trace_valid_o,
   input  logic                       trace_ready_i,
   output logic [XLEN-1:0]            trace_pc_o,
   output logic [XLEN-1:0]            trace_instr_o,
   output logic [4:0]                 trace_rd_addr_o,
   output logic [XLEN-1:0]            trace_rd_data_o,
   output logic [SEQ_W-1:0]           trace_seq_o,
`ifdef RETIRE_TS_EN
   output logic [TS_W-1:0]            trace_ts_o,
`endif
   output logic [$clog2(DEPTH):0]     level_o,
   output logic [DROP_W-1:0]          drop_cnt_o,
   input  logic                       clr_drop_i
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  instr;
      logic [4:0]       rd_addr;
      logic [XLEN-1:0]  rd_data;
      logic [SEQ_W-1:0] seq;
`ifdef RETIRE_TS_EN
      logic [TS_W-1:0]  ts;
`endif
   } entry_t;

   entry_t            r_mem [DEPTH];
   logic [AW:0]       r_wr_ptr;
   logic [AW:0]       r_rd_ptr;
   logic [AW:0]       r_level;
   logic [SEQ_W-1:0]  r_seq;
   logic [DROP_W-1:0] r_drop;
`ifdef RETIRE_TS_EN
   logic [TS_W-1:0]   r_ts;
`endif

   logic   w_cap;
   logic   w_empty;
   logic   w_full;
   logic   w_pop;
   logic   w_push;
   logic   w_drop;
   entry_t w_new;
   entry_t w_head;

   // All-zero instruction words are flushed bubbles, never real retires.
   assign w_cap   = cap_en_i & ~ret_stall_i & (ret_instr_i != '0);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = ~w_empty & trace_ready_i;
   assign w_push  = w_cap & (~w_full | w_pop);
   assign w_drop  = w_cap & w_full & ~w_pop;

   always_comb begin
      w_new         = '0;
      w_new.pc      = ret_pc_i;
      w_new.instr   = ret_instr_i;
      w_new.rd_addr = ret_rd_addr_i;
      w_new.rd_data = ret_rd_data_i;
      w_new.seq     = r_seq;
`ifdef RETIRE_TS_EN
      w_new.ts      = r_ts;
`endif
   end

   // Storage is not reset; contents are only observable through the pointers.
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= w_new;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_seq    <= '0;
         r_drop   <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
         // Sequence advances on every capture so dropped retires leave visible gaps.
         if (w_cap) begin
            r_seq <= r_seq + SEQ_W'(1);
         end
         if (clr_drop_i) begin
            r_drop <= '0;
         end else if (w_drop && (r_drop != '1)) begin
            r_drop <= r_drop + DROP_W'(1);
         end
      end
   end

`ifdef RETIRE_TS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ts <= '0;
      end else begin
         r_ts <= r_ts + TS_W'(1);
      end
   end
`endif

   assign w_head          = r_mem[r_rd_ptr[AW-1:0]];
   assign trace_valid_o   = ~w_empty;
   assign trace_pc_o      = w_head.pc;
   assign trace_instr_o   = w_head.instr;
   assign trace_rd_addr_o = w_head.rd_addr;
   assign trace_rd_data_o = w_head.rd_data;
   assign trace_seq_o     = w_head.seq;
`ifdef RETIRE_TS_EN
   assign trace_ts_o      = w_head.ts;
`endif
   assign level_o         = r_level;
   assign drop_cnt_o      = r_drop;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed self-checking bench for retire_trace_buffer (DEPTH=8, DROP_W=4).
module tb_retire_trace_buffer;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned SEQ_W  = 16;
   localparam int unsigned DROP_W = 4;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              cap_en_i;
   logic [XLEN-1:0]   ret_pc_i;
   logic [XLEN-1:0]   ret_instr_i;
   logic [4:0]        ret_rd_addr_i;
   logic [XLEN-1:0]   ret_rd_data_i;
   logic              ret_stall_i;
   logic              trace_valid_o;
   logic              trace_ready_i;
   logic [XLEN-1:0]   trace_pc_o;
   logic [XLEN-1:0]   trace_instr_o;
   logic [4:0]        trace_rd_addr_o;
   logic [XLEN-1:0]   trace_rd_data_o;
   logic [SEQ_W-1:0]  trace_seq_o;
`ifdef RETIRE_TS_EN
   logic [31:0]       trace_ts_o;
`endif
   logic [$clog2(DEPTH):0] level_o;
   logic [DROP_W-1:0] drop_cnt_o;
   logic              clr_drop_i;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk = ~clk;

   retire_trace_buffer #(
      .XLEN   (XLEN),
      .DEPTH  (DEPTH),
      .SEQ_W  (SEQ_W),
      .DROP_W (DROP_W)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .cap_en_i        (cap_en_i),
      .ret_pc_i        (ret_pc_i),
      .ret_instr_i     (ret_instr_i),
      .ret_rd_addr_i   (ret_rd_addr_i),
      .ret_rd_data_i   (ret_rd_data_i),
      .ret_stall_i     (ret_stall_i),
      .trace_valid_o   (trace_valid_o),
      .trace_ready_i   (trace_ready_i),
      .trace_pc_o      (trace_pc_o),
      .trace_instr_o   (trace_instr_o),
      .trace_rd_addr_o (trace_rd_addr_o),
      .trace_rd_data_o (trace_rd_data_o),
      .trace_seq_o     (trace_seq_o),
`ifdef RETIRE_TS_EN
      .trace_ts_o      (trace_ts_o),
`endif
      .level_o         (level_o),
      .drop_cnt_o      (drop_cnt_o),
      .clr_drop_i      (clr_drop_i)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic cap(input logic [31:0] pc, input logic [31:0] instr);
      cap_en_i      = 1'b1;
      ret_stall_i   = 1'b0;
      ret_pc_i      = pc;
      ret_instr_i   = instr;
      ret_rd_addr_i = pc[6:2];
      ret_rd_data_i = ~pc;
   endtask

   task automatic idle();
      cap_en_i    = 1'b0;
      ret_stall_i = 1'b0;
      ret_instr_i = '0;
   endtask

   task automatic do_reset();
      rst_i         = 1'b1;
      idle();
      ret_pc_i      = '0;
      ret_rd_addr_i = '0;
      ret_rd_data_i = '0;
      trace_ready_i = 1'b0;
      clr_drop_i    = 1'b0;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", trace_valid_o, 0);
      chk("rst_level", level_o, 0);
      chk("rst_drop", drop_cnt_o, 0);

      // 1: three captures streamed straight through
      trace_ready_i = 1'b1;
      cap(32'h0, 32'h13);
      tick();
      chk("t1_valid0", trace_valid_o, 1);
      chk("t1_pc0", trace_pc_o, 32'h0);
      chk("t1_instr0", trace_instr_o, 32'h13);
      chk("t1_seq0", trace_seq_o, 0);
      chk("t1_lvl0", level_o, 1);
      cap(32'h4, 32'h00400093);
      tick();
      chk("t1_pc1", trace_pc_o, 32'h4);
      chk("t1_seq1", trace_seq_o, 1);
      chk("t1_rdaddr1", trace_rd_addr_o, 5'd1);
      chk("t1_rddata1", trace_rd_data_o, 32'hFFFF_FFFB);
      chk("t1_lvl1", level_o, 1);
      cap(32'h8, 32'h13);
      tick();
      chk("t1_pc2", trace_pc_o, 32'h8);
      chk("t1_seq2", trace_seq_o, 2);
      chk("t1_lvl2", level_o, 1);
      idle();
      tick();
      chk("t1_empty", trace_valid_o, 0);
      chk("t1_lvl_end", level_o, 0);

      // 2: stalls, bubbles and disabled capture push nothing
      for (int i = 0; i < 5; i++) begin
         cap(32'h40, 32'h13);
         case (i % 3)
            0: ret_stall_i = 1'b1;
            1: ret_instr_i = '0;
            default: cap_en_i = 1'b0;
         endcase
         tick();
         chk("t2_valid", trace_valid_o, 0);
         chk("t2_level", level_o, 0);
      end
      cap(32'hC, 32'h13);
      tick();
      chk("t2_valid_after", trace_valid_o, 1);
      chk("t2_seq_after", trace_seq_o, 3);
      idle();
      tick();
      chk("t2_drained", trace_valid_o, 0);

      // 3: overflow by three, then drain in order
      do_reset();
      for (int i = 0; i < DEPTH + 3; i++) begin
         cap(32'(i * 4), 32'(32'h100 + i));
         tick();
      end
      idle();
      chk("t3_level_full", level_o, DEPTH);
      chk("t3_drops", drop_cnt_o, 3);
      trace_ready_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("t3_drain_seq", trace_seq_o, 64'(i));
         chk("t3_drain_pc", trace_pc_o, 64'(i * 4));
         tick();
      end
      chk("t3_empty", trace_valid_o, 0);
      trace_ready_i = 1'b0;
      cap(32'h100, 32'h13);
      tick();
      idle();
      chk("t3_next_seq", trace_seq_o, DEPTH + 3);

      // 4: push and pop together while full
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         cap(32'(i * 4), 32'h13);
         tick();
      end
      chk("t4_full", level_o, DEPTH);
      cap(32'h200, 32'h13);
      trace_ready_i = 1'b1;
      chk("t4_pop_seq", trace_seq_o, 0);
      tick();
      idle();
      chk("t4_level_kept", level_o, DEPTH);
      chk("t4_no_drop", drop_cnt_o, 0);
      chk("t4_head_seq", trace_seq_o, 1);
      for (int i = 1; i <= DEPTH; i++) begin
         chk("t4_drain_seq", trace_seq_o, 64'(i));
         tick();
      end
      chk("t4_empty", trace_valid_o, 0);

      // 5: drop counter saturation and clear priority
      do_reset();
      for (int i = 0; i < DEPTH + 20; i++) begin
         cap(32'(i * 4), 32'h13);
         tick();
      end
      chk("t5_sat", drop_cnt_o, 15);
      chk("t5_level", level_o, DEPTH);
      clr_drop_i = 1'b1;
      tick();
      chk("t5_clr_vs_drop", drop_cnt_o, 0);
      clr_drop_i = 1'b0;
      tick();
      chk("t5_recount", drop_cnt_o, 1);
      idle();
      clr_drop_i = 1'b1;
      tick();
      chk("t5_clr_only", drop_cnt_o, 0);
      clr_drop_i = 1'b0;

      // 6: reset mid-operation discards contents
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cap(32'(i * 4), 32'h13);
         tick();
      end
      idle();
      chk("t6_level4", level_o, 4);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("t6_valid_rst", trace_valid_o, 0);
      chk("t6_level_rst", level_o, 0);

`ifdef RETIRE_TS_EN
      do_reset();
      repeat (10) tick();
      cap(32'h0, 32'h13);
      tick();
      idle();
      repeat (2) tick();
      cap(32'h4, 32'h13);
      tick();
      idle();
      chk("ts_first", trace_ts_o, 10);
      trace_ready_i = 1'b1;
      tick();
      chk("ts_second", trace_ts_o, 13);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
